bcd_operand_entry: RTL and testbench

- Upstream front-end for the 2-digit BCD add/subtract calculator.
- Replaces direct switch-driven operands with a button-sequenced entry.
- The user sets one BCD digit on the switches and presses ENTER; the block walks A-tens, A-ones, B-tens, B-ones and then presents four latched digits plus the operator, with a valid flag.
- Outputs drive the adder/subtractor operand inputs and the operand HEX displays directly.

---
 rtl/bcd_operand_entry_if.sv | 30 +++
 rtl/bcd_operand_entry.sv | 154 +++++++++++++++
 tb/tb_bcd_operand_entry.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_operand_entry_if.sv
// Operand-entry bus: switch/button inputs in, latched operands out.
// Handshake: operands_valid is a level-valid with no ready; the four digits
// and op are stable and meaningful whenever operands_valid is high, and the
// consumer samples them at will. digit_err is a single-cycle strobe.
interface bcd_operand_entry_if;
   logic [3:0] digit_in;
   logic       op_in;
   logic       enter_n;
   logic       clear_n;
   logic [3:0] a_tens;
   logic [3:0] a_ones;
   logic [3:0] b_tens;
   logic [3:0] b_ones;
   logic       op;
   logic       operands_valid;
   logic [2:0] entry_state;
   logic       digit_err;

   // Drives switches/buttons, observes operands.
   modport master (
      output digit_in, op_in, enter_n, clear_n,
      input  a_tens, a_ones, b_tens, b_ones, op, operands_valid, entry_state, digit_err
   );

   // The entry block itself.
   modport slave (
      input  digit_in, op_in, enter_n, clear_n,
      output a_tens, a_ones, b_tens, b_ones, op, operands_valid, entry_state, digit_err
   );
endinterface

// File: rtl/bcd_operand_entry.sv
// Button-sequenced BCD operand entry: debounces ENTER/CLEAR, walks the four
// digit slots, then holds the two operands and operator until the next ENTER.
module bcd_operand_entry #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input logic                 CLOCK_50,
   input logic                 rst_n,
   bcd_operand_entry_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_A_T   = 3'b000,
      ST_A_O   = 3'b001,
      ST_B_T   = 3'b010,
      ST_B_O   = 3'b011,
      ST_READY = 3'b100
   } state_t;

   localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

   // Button index 0 = ENTER, 1 = CLEAR. All levels active-low (1 = released).
   logic [1:0]       btn_raw;
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [1:0]       db_q, db_d;
   logic [1:0]       press_q, press_d;
   logic [1:0][15:0] cnt_q, cnt_d;

   state_t     state_q, state_d;
   logic [3:0] a_tens_q, a_tens_d;
   logic [3:0] a_ones_q, a_ones_d;
   logic [3:0] b_tens_q, b_tens_d;
   logic [3:0] b_ones_q, b_ones_d;
   logic       op_q, op_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;

   logic enter_ev, clear_ev;

   assign btn_raw  = {bus.clear_n, bus.enter_n};
   assign enter_ev = press_q[0];
   assign clear_ev = press_q[1];

   // Synchronize, debounce and edge-detect both buttons.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      db_d    = db_q;
      cnt_d   = cnt_q;
      press_d = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i]  = sync2_q[i];
               cnt_d[i] = 16'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end else begin
            cnt_d[i] = 16'd0;
         end
         // Only the released->pressed transition is an event.
         press_d[i] = db_q[i] & ~db_d[i];
      end
   end

   // Entry sequencer: CLEAR beats ENTER; bad digits are rejected with a strobe.
   always_comb begin
      state_d  = state_q;
      a_tens_d = a_tens_q;
      a_ones_d = a_ones_q;
      b_tens_d = b_tens_q;
      b_ones_d = b_ones_q;
      op_d     = op_q;
      err_d    = 1'b0;
      if (clear_ev) begin
         a_tens_d = 4'd0;
         a_ones_d = 4'd0;
         b_tens_d = 4'd0;
         b_ones_d = 4'd0;
         op_d     = 1'b0;
         state_d  = ST_A_T;
      end else if (enter_ev) begin
         if (state_q == ST_READY) begin
            // Start a new entry; op is kept until the next pass through B_O.
            a_tens_d = 4'd0;
            a_ones_d = 4'd0;
            b_tens_d = 4'd0;
            b_ones_d = 4'd0;
            state_d  = ST_A_T;
         end else if (bus.digit_in > 4'd9) begin
            err_d = 1'b1;
         end else begin
            case (state_q)
               ST_A_T: begin a_tens_d = bus.digit_in; state_d = ST_A_O; end
               ST_A_O: begin a_ones_d = bus.digit_in; state_d = ST_B_T; end
               ST_B_T: begin b_tens_d = bus.digit_in; state_d = ST_B_O; end
               ST_B_O: begin
                  b_ones_d = bus.digit_in;
                  op_d     = bus.op_in;
                  state_d  = ST_READY;
               end
               default: state_d = ST_A_T;
            endcase
         end
      end
      // Illegal encodings recover to the first slot.
      if (3'(state_q) > 3'b100) state_d = ST_A_T;
      valid_d = (state_d == ST_READY);
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         db_q     <= 2'b11;
         press_q  <= 2'b00;
         cnt_q    <= '0;
         state_q  <= ST_A_T;
         a_tens_q <= 4'd0;
         a_ones_q <= 4'd0;
         b_tens_q <= 4'd0;
         b_ones_q <= 4'd0;
         op_q     <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_q     <= db_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         a_tens_q <= a_tens_d;
         a_ones_q <= a_ones_d;
         b_tens_q <= b_tens_d;
         b_ones_q <= b_ones_d;
         op_q     <= op_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign bus.a_tens         = a_tens_q;
   assign bus.a_ones         = a_ones_q;
   assign bus.b_tens         = b_tens_q;
   assign bus.b_ones         = b_ones_q;
   assign bus.op             = op_q;
   assign bus.operands_valid = valid_q;
   assign bus.entry_state    = state_q;
   assign bus.digit_err      = err_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Bench for bcd_operand_entry: directed scenarios plus randomized button
// traffic, checked by a change-driven monitor against a slot-based model.
module tb_bcd_operand_entry;

   logic clk;
   logic rst_n;

   bcd_operand_entry_if bus ();

   bcd_operand_entry #(.DEBOUNCE_CYCLES(16'd4)) dut (
      .CLOCK_50 (clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   logic [21:0] exp_q[$];
   int          n_tests;
   int          n_fail;
   logic        mon_en;

   // Reference model: slot index 0..3 for digits, 4 = operands complete.
   int          m_state;
   logic [3:0]  m_dig[4];
   logic        m_op;
   logic [21:0] m_last;

   function automatic logic [21:0] dut_snap();
      return {bus.a_tens, bus.a_ones, bus.b_tens, bus.b_ones, bus.op,
              bus.operands_valid, bus.entry_state, bus.digit_err};
   endfunction

   function automatic logic [21:0] model_snap(input logic err);
      return {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_op,
              (m_state == 4), 3'(m_state), err};
   endfunction

   task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic model_push(input logic [21:0] s);
      if (s != m_last) begin
         exp_q.push_back(s);
         m_last = s;
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_op    = 1'b0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_last  = '0;
   endtask

   task automatic model_apply(input logic en, input logic cl, input logic [3:0] d, input logic o);
      if (cl) begin
         for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
         m_op    = 1'b0;
         m_state = 0;
         model_push(model_snap(1'b0));
      end else if (en) begin
         if (m_state == 4) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
            m_state = 0;
            model_push(model_snap(1'b0));
         end else if (d > 4'd9) begin
            model_push(model_snap(1'b1));
            model_push(model_snap(1'b0));
         end else begin
            m_dig[m_state] = d;
            if (m_state == 3) m_op = o;
            m_state++;
            model_push(model_snap(1'b0));
         end
      end
   endtask

   // ---------------- monitor ----------------
   task automatic monitor_loop();
      logic [21:0] cur, prev, e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = dut_snap();
         if (mon_en) begin
            if (cur[0]) begin
               n_tests++;
               if (prev[0]) begin
                  n_fail++;
                  $display("FAIL err_pulse act=2_cycles exp=1_cycle");
               end
            end
            if (cur != prev) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_change act=%h exp=no_change", cur);
               end else begin
                  e = exp_q.pop_front();
                  if (cur !== e) begin
                     n_fail++;
                     $display("FAIL out_change act=%h exp=%h", cur, e);
                  end
               end
            end
         end
         prev = cur;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_action(input logic en, input logic cl, input logic [3:0] d,
                            input logic o, input logic bounce);
      @(posedge clk); #1;
      bus.digit_in = d;
      bus.op_in    = o;
      if (bounce) begin
         if (en) bus.enter_n = 1'b0;
         if (cl) bus.clear_n = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
         bus.enter_n = 1'b1;
         bus.clear_n = 1'b1;
         repeat (2) @(posedge clk);
         #1;
      end
      model_apply(en, cl, d, o);
      if (en) bus.enter_n = 1'b0;
      if (cl) bus.clear_n = 1'b0;
      repeat ($urandom_range(6, 20)) @(posedge clk);
      #1;
      bus.enter_n = 1'b1;
      bus.clear_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      // Switch movement between presses must not matter.
      bus.digit_in = 4'($urandom_range(0, 15));
      bus.op_in    = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout act=%0d_pending exp=0_pending", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] d;
      int         a;
      n_tests = 0;
      n_fail  = 0;
      mon_en  = 1'b0;
      model_reset();
      rst_n        = 1'b0;
      bus.digit_in = 4'd0;
      bus.op_in    = 1'b0;
      bus.enter_n  = 1'b1;
      bus.clear_n  = 1'b1;
      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", dut_snap(), 22'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Short glitch: no event.
      bus.enter_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.enter_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("glitch_state", {19'd0, bus.entry_state}, 22'd0);

      // First press with exact latency, held ~20 cycles.
      bus.digit_in = 4'd4;
      bus.op_in    = 1'b0;
      model_apply(1'b1, 1'b0, 4'd4, 1'b0);
      bus.enter_n  = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("lat_early", {18'd0, bus.a_tens}, 22'd0);
      @(posedge clk); #1;
      check("lat_first", {18'd0, bus.a_tens}, 22'd4);
      repeat (14) @(posedge clk);
      #1;
      bus.enter_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      do_action(1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
      do_action(1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
      do_action(1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
      drain();
      check("entry_4729", dut_snap(), {4'd4, 4'd7, 4'd2, 4'd9, 1'b1, 1'b1, 3'b100, 1'b0});

      // READY -> ENTER clears digits, keeps op.
      do_action(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      do_action(1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
      do_action(1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
      do_action(1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      do_action(1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
      drain();
      check("ready_1234", dut_snap(), {4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 3'b100, 1'b0});
      do_action(1'b1, 1'b0, 4'd8, 1'b0, 1'b0);
      drain();
      check("ready_exit", dut_snap(), {16'd0, 1'b1, 1'b0, 3'b000, 1'b0});

      // Rejected digit in A_O, then a good one.
      do_action(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      do_action(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
      drain();
      check("err_hold", dut_snap(), {4'd1, 4'd0, 8'd0, 1'b1, 1'b0, 3'b001, 1'b0});
      do_action(1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
      drain();
      check("err_recover", dut_snap(), {4'd1, 4'd5, 8'd0, 1'b1, 1'b0, 3'b010, 1'b0});

      // Simultaneous CLEAR and ENTER in B_T.
      do_action(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
      drain();
      check("clear_wins", dut_snap(), 22'h0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         a = $urandom_range(0, 9);
         if ($urandom_range(0, 9) < 7) d = 4'($urandom_range(0, 9));
         else                          d = 4'($urandom_range(10, 15));
         do_action((a < 7) || (a == 9), (a >= 7), d, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end
      drain();

      // Async reset in B_O, mid-debounce.
      do_action(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      do_action(1'b1, 1'b0, 4'd6, 1'b0, 1'b0);
      do_action(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
      do_action(1'b1, 1'b0, 4'd8, 1'b0, 1'b0);
      drain();
      check("pre_rst_bo", {19'd0, bus.entry_state}, 22'd3);
      @(posedge clk); #1;
      bus.enter_n = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("async_rst", dut_snap(), 22'h0);
      bus.enter_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      mon_en = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("post_rst_idle", dut_snap(), 22'h0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
